// File: rtl/l1_port_arbiter.sv
// Shares one L1 AXI master between N_PORTS worker requesters.
// AR and AW are arbitrated independently; R and B are routed back to workers by ID.
module l1_port_arbiter #(
  parameter int unsigned N_PORTS = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned WCNT_W  = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  // worker read address
  input  logic [N_PORTS-1:0]         s_arvalid,
  output logic [N_PORTS-1:0]         s_arready,
  input  logic [N_PORTS-1:0][31:0]   s_araddr,
  input  logic [N_PORTS-1:0][7:0]    s_arlen,
  input  logic [N_PORTS-1:0][2:0]    s_arsize,
  // worker read data
  output logic [N_PORTS-1:0]         s_rvalid,
  input  logic [N_PORTS-1:0]         s_rready,
  output logic [N_PORTS-1:0][63:0]   s_rdata,
  output logic [N_PORTS-1:0]         s_rlast,
  output logic [N_PORTS-1:0][1:0]    s_rresp,
  // worker single-beat write
  input  logic [N_PORTS-1:0]         s_awvalid,
  output logic [N_PORTS-1:0]         s_awready,
  input  logic [N_PORTS-1:0][31:0]   s_awaddr,
  input  logic [N_PORTS-1:0][31:0]   s_wdata,
  input  logic [N_PORTS-1:0][3:0]    s_wstrb,
  // worker write response
  output logic [N_PORTS-1:0]         s_bvalid,
  output logic [N_PORTS-1:0][1:0]    s_bresp,
  // shared L1 master
  output logic                       m_arvalid,
  input  logic                       m_arready,
  output logic [31:0]                m_araddr,
  output logic [7:0]                 m_arlen,
  output logic [2:0]                 m_arsize,
  output logic [ID_W-1:0]            m_arid,
  input  logic                       m_rvalid,
  output logic                       m_rready,
  input  logic [63:0]                m_rdata,
  input  logic                       m_rlast,
  input  logic [1:0]                 m_rresp,
  input  logic [ID_W-1:0]            m_rid,
  output logic                       m_awvalid,
  input  logic                       m_awready,
  output logic [31:0]                m_awaddr,
  output logic [7:0]                 m_awlen,
  output logic [ID_W-1:0]            m_awid,
  output logic                       m_wvalid,
  input  logic                       m_wready,
  output logic [31:0]                m_wdata,
  output logic [3:0]                 m_wstrb,
  output logic                       m_wlast,
  input  logic                       m_bvalid,
  output logic                       m_bready,
  input  logic [1:0]                 m_bresp,
  input  logic [ID_W-1:0]            m_bid,
  output logic                       err_sticky,
  output logic                       idle
);

  logic [ID_W-1:0]                ar_ptr, aw_ptr;
  logic                           ar_hold, aw_hold;
  logic [ID_W-1:0]                ar_hold_idx, aw_hold_idx;
  logic [N_PORTS-1:0]             rd_busy;
  logic [N_PORTS-1:0][WCNT_W-1:0] wr_cnt;

  logic [ID_W:0]      ar_pick, aw_pick;
  logic [ID_W-1:0]    ar_sel, aw_sel;
  logic               ar_req, aw_req;
  logic [N_PORTS-1:0] aw_full, b_uflow, r_done;

  // Returns {found, index} of the first eligible port at or after ptr.
  function automatic logic [ID_W:0] rr_pick(input logic [N_PORTS-1:0] elig,
                                            input logic [ID_W-1:0] ptr);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] c;
    res = '0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      c = ID_W'((32'(ptr) + k) % N_PORTS);
      if (!res[ID_W] && elig[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  function automatic logic [ID_W-1:0] ptr_next(input logic [ID_W-1:0] p);
    return (32'(p) == N_PORTS - 1) ? '0 : p + ID_W'(1);
  endfunction

  // An offer left unaccepted last cycle stays locked to its port so the
  // master sees stable AR/AW payloads until the handshake completes.
  always_comb begin
    for (int unsigned i = 0; i < N_PORTS; i++) aw_full[i] = &wr_cnt[i];
    ar_pick = rr_pick(s_arvalid & ~rd_busy, ar_ptr);
    aw_pick = rr_pick(s_awvalid & ~aw_full, aw_ptr);
    ar_sel  = ar_hold ? ar_hold_idx : ar_pick[ID_W-1:0];
    aw_sel  = aw_hold ? aw_hold_idx : aw_pick[ID_W-1:0];
    ar_req  = rstn && (ar_hold ? s_arvalid[ar_hold_idx] : ar_pick[ID_W]);
    aw_req  = rstn && (aw_hold ? s_awvalid[aw_hold_idx] : aw_pick[ID_W]);
  end

  always_comb begin
    m_arvalid = ar_req;
    m_araddr  = s_araddr[ar_sel];
    m_arlen   = s_arlen[ar_sel];
    m_arsize  = s_arsize[ar_sel];
    m_arid    = ar_sel;
    m_awvalid = aw_req;
    m_awaddr  = s_awaddr[aw_sel];
    m_awlen   = '0;
    m_awid    = aw_sel;
    m_wvalid  = aw_req;
    m_wlast   = aw_req;
    m_wdata   = s_wdata[aw_sel];
    m_wstrb   = s_wstrb[aw_sel];
    m_bready  = 1'b1;
    s_arready = '0;
    s_awready = '0;
    s_arready[ar_sel] = ar_req && m_arready;
    s_awready[aw_sel] = aw_req && m_awready && m_wready;
  end

  always_comb begin
    m_rready = (32'(m_rid) < N_PORTS) ? s_rready[m_rid] : 1'b0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      s_rvalid[i] = m_rvalid && (m_rid == ID_W'(i));
      s_rdata[i]  = m_rdata;
      s_rlast[i]  = m_rlast;
      s_rresp[i]  = m_rresp;
      s_bvalid[i] = m_bvalid && (m_bid == ID_W'(i));
      s_bresp[i]  = m_bresp;
      r_done[i]   = s_rvalid[i] && s_rready[i] && m_rlast;
      b_uflow[i]  = s_bvalid[i] && (wr_cnt[i] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ar_ptr      <= '0;
      aw_ptr      <= '0;
      ar_hold     <= 1'b0;
      aw_hold     <= 1'b0;
      ar_hold_idx <= '0;
      aw_hold_idx <= '0;
      rd_busy     <= '0;
      wr_cnt      <= '0;
      err_sticky  <= 1'b0;
    end else begin
      ar_hold     <= ar_req && !m_arready;
      aw_hold     <= aw_req && !(m_awready && m_wready);
      ar_hold_idx <= ar_sel;
      aw_hold_idx <= aw_sel;
      if (ar_req && m_arready) ar_ptr <= ptr_next(ar_sel);
      if (aw_req && m_awready && m_wready) aw_ptr <= ptr_next(aw_sel);
      rd_busy <= (rd_busy & ~r_done) | s_arready;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        if (s_awready[i] && !s_bvalid[i])
          wr_cnt[i] <= wr_cnt[i] + WCNT_W'(1);
        else if (!s_awready[i] && s_bvalid[i] && wr_cnt[i] != '0)
          wr_cnt[i] <= wr_cnt[i] - WCNT_W'(1);
      end
      if ((m_rvalid && m_rready && m_rresp != 2'b00) ||
          (m_bvalid && m_bresp != 2'b00) || (|b_uflow))
        err_sticky <= 1'b1;
    end
  end

  assign idle = !(|rd_busy) && !(|wr_cnt);

endmodule

// File: tb/tb_l1_port_arbiter.sv
// Scoreboard bench for l1_port_arbiter: tasks push expected transfers, negedge monitors pop and compare.
module tb_l1_port_arbiter;

  logic              clk = 1'b0;
  logic              rstn;
  logic [3:0]        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [3:0][31:0]  s_araddr, s_awaddr, s_wdata;
  logic [3:0][7:0]   s_arlen;
  logic [3:0][2:0]   s_arsize;
  logic [3:0][63:0]  s_rdata;
  logic [3:0][1:0]   s_rresp, s_bresp;
  logic [3:0]        s_awvalid, s_awready, s_bvalid;
  logic [3:0][3:0]   s_wstrb;
  logic              m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [31:0]       m_araddr, m_awaddr, m_wdata;
  logic [7:0]        m_arlen, m_awlen;
  logic [2:0]        m_arsize;
  logic [1:0]        m_arid, m_rid, m_awid, m_bid, m_rresp, m_bresp;
  logic [63:0]       m_rdata;
  logic              m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
  logic [3:0]        m_wstrb;
  logic              m_bvalid, m_bready, err_sticky, idle;

  int vectors = 0;
  int miscompares = 0;

  logic [33:0] ar_q[$];  // {id, addr}
  logic [65:0] aw_q[$];  // {id, addr, data}
  logic [65:0] r_q[$];   // {port, data}
  logic [1:0]  b_q[$];   // port

  l1_port_arbiter #(.N_PORTS(4), .ID_W(2), .WCNT_W(4)) dut (
    .clk(clk), .rstn(rstn),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rlast(s_rlast), .s_rresp(s_rresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arid(m_arid),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_rlast(m_rlast), .m_rresp(m_rresp), .m_rid(m_rid),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_awlen(m_awlen), .m_awid(m_awid),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid),
    .err_sticky(err_sticky), .idle(idle)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [33:0] e;
    if (m_arvalid && m_arready) begin
      vectors++;
      if (ar_q.size() == 0) begin
        miscompares++;
        $display("FAIL ar_unexpected: got id=%0d addr=%h, required no AR", m_arid, m_araddr);
      end else begin
        e = ar_q.pop_front();
        if ({m_arid, m_araddr} !== e || s_arready !== (4'b1 << e[33:32])) begin
          miscompares++;
          $display("FAIL ar_grant: got id=%0d addr=%h s_arready=%b, required id=%0d addr=%h",
                   m_arid, m_araddr, s_arready, e[33:32], e[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [65:0] e;
    if (m_awvalid && m_awready && m_wready) begin
      vectors++;
      if (aw_q.size() == 0) begin
        miscompares++;
        $display("FAIL aw_unexpected: got id=%0d addr=%h, required no AW", m_awid, m_awaddr);
      end else begin
        e = aw_q.pop_front();
        if ({m_awid, m_awaddr, m_wdata, m_wvalid, m_wlast, m_awlen} !== {e, 1'b1, 1'b1, 8'd0} ||
            s_awready !== (4'b1 << e[65:64])) begin
          miscompares++;
          $display("FAIL aw_grant: got id=%0d addr=%h data=%h wv=%b wl=%b len=%0d s_awready=%b, required id=%0d addr=%h data=%h",
                   m_awid, m_awaddr, m_wdata, m_wvalid, m_wlast, m_awlen, s_awready,
                   e[65:64], e[63:32], e[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [65:0] e;
    if (m_rvalid) begin
      vectors++;
      if (r_q.size() == 0) begin
        miscompares++;
        $display("FAIL r_unexpected: got s_rvalid=%b, required no beat", s_rvalid);
      end else begin
        e = r_q.pop_front();
        if (s_rvalid !== (4'b1 << e[65:64]) || s_rdata[e[65:64]] !== e[63:0]) begin
          miscompares++;
          $display("FAIL r_route: got s_rvalid=%b data=%h, required s_rvalid=%b data=%h",
                   s_rvalid, s_rdata[e[65:64]], 4'b1 << e[65:64], e[63:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] e;
    if (m_bvalid) begin
      vectors++;
      if (b_q.size() == 0) begin
        miscompares++;
        $display("FAIL b_unexpected: got s_bvalid=%b, required no B", s_bvalid);
      end else begin
        e = b_q.pop_front();
        if (s_bvalid !== (4'b1 << e) || m_bready !== 1'b1) begin
          miscompares++;
          $display("FAIL b_route: got s_bvalid=%b bready=%b, required s_bvalid=%b bready=1",
                   s_bvalid, m_bready, 4'b1 << e);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    m_arready = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
    m_rvalid = 1'b0; m_bvalid = 1'b0;
    tick(); tick();
    #1;
    vectors++;
    if ({m_arvalid, m_awvalid, idle, err_sticky} !== 4'b0010) begin
      miscompares++;
      $display("FAIL reset_state: got arv=%b awv=%b idle=%b err=%b, required 0 0 1 0",
               m_arvalid, m_awvalid, idle, err_sticky);
    end
    s_arvalid = '0; s_awvalid = '0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic r_beat(input logic [1:0] id, input logic [63:0] d,
                        input logic last, input logic [1:0] resp);
    m_rvalid = 1'b1; m_rid = id; m_rdata = d; m_rlast = last; m_rresp = resp;
    r_q.push_back({id, d});
    #1;
    vectors++;
    if (m_rready !== 1'b1) begin
      miscompares++;
      $display("FAIL r_ready: got m_rready=%b, required 1", m_rready);
    end
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
  endtask

  task automatic b_beat(input logic [1:0] id, input logic [1:0] resp);
    m_bvalid = 1'b1; m_bid = id; m_bresp = resp;
    b_q.push_back(id);
    tick();
    m_bvalid = 1'b0; m_bresp = 2'b00;
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %b, required %b", name, got, want);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    s_arvalid = 4'b1111;
    s_awvalid = 4'b1111;
    do_reset();
    #1;
    check_bit("reset_idle_after", idle, 1'b1);
    check_bit("reset_arready", |s_arready, 1'b0);
    tick();
  endtask

  task automatic test_ar_round_robin();
    s_araddr[0] = 32'h0000_1000; s_araddr[2] = 32'h0000_2000;
    s_arlen[0] = 8'd0; s_arlen[2] = 8'd0;
    s_arvalid = 4'b0101; m_arready = 1'b1;
    ar_q.push_back({2'd0, 32'h0000_1000});
    ar_q.push_back({2'd2, 32'h0000_2000});
    tick(); s_arvalid[0] = 1'b0;
    #1; check_bit("rr_idle_busy", idle, 1'b0);
    tick(); s_arvalid[2] = 1'b0; m_arready = 1'b0;
    r_beat(2'd0, 64'hA0, 1'b1, 2'b00);
    r_beat(2'd2, 64'hA2, 1'b1, 2'b00);
    #1; check_bit("rr_idle_clear", idle, 1'b1);
    tick();
  endtask

  task automatic test_read_burst();
    s_araddr[1] = 32'h0000_5000; s_arlen[1] = 8'd3; s_arvalid[1] = 1'b1; m_arready = 1'b1;
    ar_q.push_back({2'd1, 32'h0000_5000});
    #1; check_bit("burst_arlen", m_arlen === 8'd3, 1'b1);
    tick();
    for (int b = 0; b < 4; b++) begin
      #1; check_bit("burst_ar_blocked", m_arvalid, 1'b0);
      r_beat(2'd1, 64'hB000 + 64'(b), b == 3, 2'b00);
    end
    ar_q.push_back({2'd1, 32'h0000_5000});
    #1; check_bit("burst_ar_unblocked", m_arvalid, 1'b1);
    tick(); s_arvalid[1] = 1'b0; m_arready = 1'b0;
    r_beat(2'd1, 64'hB100, 1'b1, 2'b00);
  endtask

  task automatic test_ar_hold();
    do_reset();
    s_araddr[3] = 32'h0000_3000; s_arvalid[3] = 1'b1; m_arready = 1'b0;
    tick();
    s_araddr[0] = 32'h0000_4000; s_arvalid[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++;
      if ({m_arvalid, m_arid, m_araddr, s_arready} !== {1'b1, 2'd3, 32'h0000_3000, 4'b0000}) begin
        miscompares++;
        $display("FAIL ar_hold: got v=%b id=%0d addr=%h rdy=%b, required v=1 id=3 addr=00003000 rdy=0000",
                 m_arvalid, m_arid, m_araddr, s_arready);
      end
      tick();
    end
    m_arready = 1'b1;
    ar_q.push_back({2'd3, 32'h0000_3000});
    ar_q.push_back({2'd0, 32'h0000_4000});
    tick(); s_arvalid[3] = 1'b0;
    tick(); s_arvalid[0] = 1'b0; m_arready = 1'b0;
    r_beat(2'd3, 64'hC3, 1'b1, 2'b00);
    r_beat(2'd0, 64'hC0, 1'b1, 2'b00);
  endtask

  task automatic test_write_full();
    do_reset();
    m_awready = 1'b1; m_wready = 1'b1; s_awvalid[0] = 1'b1; s_wstrb[0] = 4'hF;
    for (int k = 0; k < 15; k++) begin
      s_awaddr[0] = 32'h100 + 32'(k * 4); s_wdata[0] = 32'hD000_0000 + 32'(k);
      aw_q.push_back({2'd0, 32'h100 + 32'(k * 4), 32'hD000_0000 + 32'(k)});
      tick();
    end
    s_awaddr[0] = 32'h200; s_wdata[0] = 32'hD000_00FF;
    #1; check_bit("wr_full_stall", s_awready[0], 1'b0);
    check_bit("wr_full_awvalid", m_awvalid, 1'b0);
    m_bvalid = 1'b1; m_bid = 2'd0; m_bresp = 2'b00; b_q.push_back(2'd0);
    #1; check_bit("wr_full_during_b", s_awready[0], 1'b0);
    tick(); m_bvalid = 1'b0;
    aw_q.push_back({2'd0, 32'h200, 32'hD000_00FF});
    #1; check_bit("wr_after_b_accept", s_awready[0], 1'b1);
    tick(); s_awvalid[0] = 1'b1;
    #1; check_bit("wr_full_again", s_awready[0], 1'b0);
    s_awvalid[0] = 1'b0;
    for (int k = 0; k < 14; k++) b_beat(2'd0, 2'b00);
    #1; check_bit("wr_one_left", idle, 1'b0);
    b_beat(2'd0, 2'b00);
    #1; check_bit("wr_drained_idle", idle, 1'b1);
    check_bit("wr_no_err", err_sticky, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    s_awvalid[2] = 1'b1; s_awaddr[2] = 32'h2200; s_wdata[2] = 32'h2222; s_wstrb[2] = 4'h3;
    aw_q.push_back({2'd2, 32'h2200, 32'h2222});
    tick();
    s_awaddr[2] = 32'h2204; s_wdata[2] = 32'h2223;
    aw_q.push_back({2'd2, 32'h2204, 32'h2223});
    m_bvalid = 1'b1; m_bid = 2'd2; m_bresp = 2'b00; b_q.push_back(2'd2);
    tick();
    s_awvalid[2] = 1'b0; m_bvalid = 1'b0;
    #1; check_bit("same_cycle_busy", idle, 1'b0);
    b_beat(2'd2, 2'b00);
    #1; check_bit("same_cycle_idle", idle, 1'b1);
    check_bit("same_cycle_no_err", err_sticky, 1'b0);
    r_beat(2'd1, 64'hE1, 1'b1, 2'b10);
    #1; check_bit("rresp_err_set", err_sticky, 1'b1);
    tick(); tick(); tick();
    check_bit("rresp_err_sticky", err_sticky, 1'b1);
    do_reset();
    #1; check_bit("err_cleared_by_reset", err_sticky, 1'b0);
    tick();
  endtask

  task automatic test_reset_midburst();
    m_awready = 1'b1; m_wready = 1'b1;
    s_araddr[1] = 32'h0000_7000; s_arlen[1] = 8'd7; s_arvalid[1] = 1'b1; m_arready = 1'b1;
    ar_q.push_back({2'd1, 32'h0000_7000});
    s_awvalid[0] = 1'b1; s_awaddr[0] = 32'h0700; s_wdata[0] = 32'h7777;
    aw_q.push_back({2'd0, 32'h0700, 32'h7777});
    tick();
    s_arvalid[1] = 1'b0; s_awvalid[0] = 1'b0;
    r_beat(2'd1, 64'hF0, 1'b0, 2'b00);
    r_beat(2'd1, 64'hF1, 1'b0, 2'b00);
    #1; check_bit("midburst_busy", idle, 1'b0);
    s_arvalid[2] = 1'b1; s_awvalid[1] = 1'b1;
    do_reset();
    #1; check_bit("midburst_idle_after", idle, 1'b1);
    b_beat(2'd0, 2'b00);
    #1; check_bit("stray_b_err", err_sticky, 1'b1);
    check_bit("stray_b_no_underflow", idle, 1'b1);
    r_beat(2'd1, 64'hF7, 1'b1, 2'b00);
    #1; check_bit("stray_r_idle", idle, 1'b1);
    tick();
  endtask

  initial begin
    rstn = 1'b0;
    s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_rready = '1;
    s_awvalid = '0; s_awaddr = '0; s_wdata = '0; s_wstrb = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rlast = 1'b0; m_rresp = '0; m_rid = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = '0; m_bid = '0;
    tick();
    test_reset();
    test_ar_round_robin();
    test_read_burst();
    test_ar_hold();
    test_write_full();
    test_back_to_back();
    test_reset_midburst();
    tick();
    vectors++;
    if (ar_q.size() + aw_q.size() + r_q.size() + b_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d/%0d/%0d/%0d pending, required 0/0/0/0",
               ar_q.size(), aw_q.size(), r_q.size(), b_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/l1_port_arbiter.md
L1_PORT_ARBITER -- requirements
Module: l1_port_arbiter

Interface
REQ-001 SHALL have parameter N_PORTS, default 4: number of worker requesters sharing one L1 port.
REQ-002 SHALL have parameter ID_W, default 2: AXI ID width, equal to clog2(N_PORTS).
REQ-003 SHALL have parameter WCNT_W, default 4: width of each per-port outstanding-write counter.
REQ-004 SHALL have port clk, input, 1: clock.
REQ-005 SHALL have port rstn, input, 1: synchronous, active-low reset.
REQ-006 SHALL have ports s_arvalid/s_arready/s_araddr/s_arlen/s_arsize, in/out/in/in/in, N_PORTS x (1/1/32/8/3): per-worker read address channel.
REQ-007 SHALL have ports s_rvalid/s_rready/s_rdata/s_rlast/s_rresp, out/in/out/out/out, N_PORTS x (1/1/64/1/2): per-worker read data channel.
REQ-008 SHALL have ports s_awvalid/s_awready/s_awaddr/s_wdata/s_wstrb, in/out/in/in/in, N_PORTS x (1/1/32/32/4): per-worker single-beat write; W is implied by AW.
REQ-009 SHALL have ports s_bvalid/s_bresp, out/out, N_PORTS x (1/2): per-worker write response pulse.
REQ-010 SHALL have ports m_ar*, m_r*, m_aw*, m_w*, m_b* for the shared L1 AXI master, with m_arid/m_rid/m_awid/m_bid each ID_W wide.
REQ-011 SHALL have port err_sticky, output, 1: set on any RRESP or BRESP not equal to 0.
REQ-012 SHALL have port idle, output, 1: high when no read or write is outstanding on any port.

Function
REQ-013 SHALL grant AR round-robin among eligible ports; a port is eligible when s_arvalid=1 and its rd_busy bit=0.
REQ-014 SHALL drive m_arvalid/m_araddr/m_arlen/m_arsize from the granted port and set m_arid = granted index.
REQ-015 SHALL hold the AR grant stable while m_arvalid=1 and m_arready=0; no re-arbitration mid-offer.
REQ-016 SHALL return s_arready[i] = m_arready for the granted port i only, and 0 for all other ports.
REQ-017 SHALL, on an AR handshake, set rd_busy[granted] and move the AR priority pointer to granted+1 (mod N_PORTS).
REQ-018 SHALL route R combinationally as follows:
- s_rvalid[i] = m_rvalid and (m_rid == i);
- m_rready = s_rready[m_rid];
- rdata, rlast and rresp are fanned out to all ports.
REQ-019 SHALL clear rd_busy[m_rid] on the R handshake with m_rlast=1.
REQ-020 SHALL grant AW with an independent round-robin pointer.
- Eligible: s_awvalid=1 and wr_cnt[i] is not at its max value (2^WCNT_W-1).
- m_wvalid = m_awvalid and m_wlast = m_awvalid.
- A handshake requires m_awready and m_wready together; s_awready[i] is the AND of both for the granted port.
REQ-021 SHALL set m_awid = granted index and m_awlen=0, and SHALL pass m_awaddr, m_wdata and m_wstrb from the granted port.
REQ-022 SHALL tie m_bready=1, drive s_bvalid[i] = m_bvalid and (m_bid == i), and fan s_bresp out to all ports.
REQ-023 SHALL update wr_cnt[i] each cycle:
- +1 on an AW handshake for port i;
- -1 on a B beat for port i;
- unchanged when both happen in the same cycle.
REQ-024 SHALL clamp the wr_cnt decrement at 0; a B beat arriving at count 0 sets err_sticky.
REQ-025 SHALL drive idle = (rd_busy == 0) and (all wr_cnt == 0), registered-state based, with no combinational path from inputs.
REQ-026 SHALL make a granted AR or AW visible on m_* in the same cycle as the requester's valid; arbitration is combinational from registered pointers.
REQ-027 SHALL keep the AR and AW paths fully independent; simultaneous grants on both are allowed.

Reset
REQ-028 SHALL, while rstn=0 at a clk edge, set pointers=0, rd_busy=0, wr_cnt=0 and err_sticky=0, and drive m_arvalid=0 and m_awvalid=0.
REQ-029 SHALL, on a reset during an in-flight burst, drop tracking; stale R/B beats arriving afterwards are still routed by ID and do not underflow counters (REQ-024 applies).

Verification
REQ-030 SHALL pass: ports 0 and 2 raise arvalid in the same cycle with pointer=0 -> port 0 granted, m_arid=0; after that handshake port 2 is granted with m_arid=2.
REQ-031 SHALL pass: port 1 reads with arlen=3 and m_rid=1 returns 4 beats -> only s_rvalid[1] pulses 4 times; rd_busy[1] clears after the beat with rlast; a second port-1 arvalid is blocked until then.
REQ-032 SHALL pass: m_arready held 0 for 5 cycles while port 3 waits -> grant and m_araddr remain stable even if port 0 asserts arvalid meanwhile.
REQ-033 SHALL pass: port 0 issues 15 writes with no B -> 16th s_awready=0; one B with bid=0 -> wr_cnt=14 and the write is accepted.
REQ-034 SHALL pass: an AW handshake and a B beat for port 2 in the same cycle -> wr_cnt[2] unchanged; an rresp=2 beat -> err_sticky=1 until reset.
REQ-035 SHALL pass: reset asserted mid-burst -> idle=1 after reset; a later stray B with bid=0 sets err_sticky and leaves wr_cnt[0]=0.
